// File: rtl/pit_irq_pkg.sv
// Shared constants and state encoding for the timer interrupt arbiter.
package pit_irq_pkg;

    localparam int NUM_CH_DEF = 4;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } pit_state_t;

endpackage

// File: rtl/pit_rr_pick.sv
// Combinational round-robin picker: first set request above i_last, wrapping.
module pit_rr_pick #(
    parameter int NUM_CH = 4,
    parameter int ID_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [ID_W-1:0]   i_last,
    output logic              o_any,
    output logic [ID_W-1:0]   o_id
);

    logic [ID_W-1:0] w_idx;

    always_comb begin
        o_any = 1'b0;
        o_id  = '0;
        w_idx = '0;
        // k = NUM_CH lands back on i_last itself, so it has lowest priority.
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            w_idx = ID_W'((32'(i_last) + k) % NUM_CH);
            if (!o_any && i_req[w_idx]) begin
                o_any = 1'b1;
                o_id  = w_idx;
            end
        end
    end

endmodule

// File: rtl/pit_irq_arbiter.sv
// Pending/mask latch and round-robin valid/ack presenter for timer interrupts.
// Optional lost-pulse flags enabled by defining PIT_IRQ_MISS_EN.
module pit_irq_arbiter
    import pit_irq_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    localparam int ID_W  = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] irq_pulse,
    input  logic              mask_wr,
    input  logic [NUM_CH-1:0] mask_wdata,
    output logic [NUM_CH-1:0] mask,
    output logic [NUM_CH-1:0] pending,
    output logic              irq_valid,
    output logic [ID_W-1:0]   irq_id,
    input  logic              irq_ack,
    output logic [NUM_CH-1:0] miss
);

    pit_state_t        r_state;
    logic [NUM_CH-1:0] r_pending;
    logic [NUM_CH-1:0] r_mask;
    logic              r_valid;
    logic [ID_W-1:0]   r_id;
    logic [ID_W-1:0]   r_last;

    logic [NUM_CH-1:0] w_elig;
    logic [NUM_CH-1:0] w_ack_clr;
    logic              w_any;
    logic [ID_W-1:0]   w_win;

    assign w_elig    = r_pending & ~r_mask;
    assign w_ack_clr = (r_state == PRESENT && irq_ack) ? (NUM_CH'(1) << r_id) : '0;

    pit_rr_pick #(
        .NUM_CH (NUM_CH),
        .ID_W   (ID_W)
    ) u_pick (
        .i_req  (w_elig),
        .i_last (r_last),
        .o_any  (w_any),
        .o_id   (w_win)
    );

    // A pulse coinciding with the ack of its own channel re-arms pending.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_mask    <= '1;
        end else begin
            r_pending <= (r_pending & ~w_ack_clr) | irq_pulse;
            if (mask_wr) begin
                r_mask <= mask_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_id    <= '0;
            r_last  <= ID_W'(NUM_CH - 1);
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_id    <= w_win;
                        r_valid <= 1'b1;
                        r_state <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (irq_ack) begin
                        r_last  <= r_id;
                        r_valid <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef PIT_IRQ_MISS_EN
    logic [NUM_CH-1:0] r_miss;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_miss <= '0;
        end else begin
            r_miss <= (r_miss & ~w_ack_clr) | (irq_pulse & r_pending & ~w_ack_clr);
        end
    end

    assign miss = r_miss;
`else
    assign miss = '0;
`endif

    assign mask      = r_mask;
    assign pending   = r_pending;
    assign irq_valid = r_valid;
    assign irq_id    = r_id;

endmodule

// File: tb/tb_pit_irq_arbiter.sv
// Directed vector bench for pit_irq_arbiter (NUM_CH = 4).
module tb_pit_irq_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] irq_pulse;
    logic       mask_wr;
    logic [3:0] mask_wdata;
    logic [3:0] mask;
    logic [3:0] pending;
    logic       irq_valid;
    logic [1:0] irq_id;
    logic       irq_ack;
    logic [3:0] miss;

    int n_checks = 0;
    int n_fails  = 0;

    pit_irq_arbiter #(.NUM_CH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq_pulse  (irq_pulse),
        .mask_wr    (mask_wr),
        .mask_wdata (mask_wdata),
        .mask       (mask),
        .pending    (pending),
        .irq_valid  (irq_valid),
        .irq_id     (irq_id),
        .irq_ack    (irq_ack),
        .miss       (miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst_n;
        logic [3:0] pulse;
        logic       mwr;
        logic [3:0] mdata;
        logic       ack;
        logic [3:0] pend;
        logic [3:0] mask;
        logic       vld;
        logic [1:0] id;
        logic [3:0] miss;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [3:0] p, input logic w, input logic [3:0] d,
                       input logic a, input logic [3:0] ep, input logic [3:0] em,
                       input logic ev, input logic [1:0] eid, input logic [3:0] ems);
        vec_t v;
        v = '{r, p, w, d, a, ep, em, ev, eid, ems};
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] p, input logic w, input logic [3:0] d, input logic a);
        @(negedge clk);
        rst_n      = r;
        irq_pulse  = p;
        mask_wr    = w;
        mask_wdata = d;
        irq_ack    = a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp_miss;
        int         lat;

        rst_n = 1'b0; irq_pulse = '0; mask_wr = 1'b0; mask_wdata = '0; irq_ack = 1'b0;

        //  rst  pulse  mwr mdata  ack | pend   mask   vld id  miss
        // single channel grant, ack while idle ignored
        add(0, 4'h0, 0, 4'h0, 0,  4'h0, 4'hF, 0, 2'd0, 4'h0);
        add(1, 4'h0, 1, 4'h0, 0,  4'h0, 4'h0, 0, 2'd0, 4'h0);
        add(1, 4'h0, 0, 4'h0, 1,  4'h0, 4'h0, 0, 2'd0, 4'h0);
        add(1, 4'h4, 0, 4'h0, 0,  4'h4, 4'h0, 0, 2'd0, 4'h0);
        add(1, 4'h0, 0, 4'h0, 0,  4'h4, 4'h0, 1, 2'd2, 4'h0);
        add(1, 4'h0, 0, 4'h0, 0,  4'h4, 4'h0, 1, 2'd2, 4'h0);
        add(1, 4'h0, 0, 4'h0, 1,  4'h0, 4'h0, 0, 2'd2, 4'h0);
        // round robin 0,1,3 from reset with one low cycle between grants
        add(0, 4'h0, 0, 4'h0, 0,  4'h0, 4'hF, 0, 2'd0, 4'h0);
        add(1, 4'h0, 1, 4'h0, 0,  4'h0, 4'h0, 0, 2'd0, 4'h0);
        add(1, 4'hB, 0, 4'h0, 0,  4'hB, 4'h0, 0, 2'd0, 4'h0);
        add(1, 4'h0, 0, 4'h0, 0,  4'hB, 4'h0, 1, 2'd0, 4'h0);
        add(1, 4'h0, 0, 4'h0, 1,  4'hA, 4'h0, 0, 2'd0, 4'h0);
        add(1, 4'h0, 0, 4'h0, 0,  4'hA, 4'h0, 1, 2'd1, 4'h0);
        add(1, 4'h0, 0, 4'h0, 1,  4'h8, 4'h0, 0, 2'd1, 4'h0);
        add(1, 4'h0, 0, 4'h0, 0,  4'h8, 4'h0, 1, 2'd3, 4'h0);
        add(1, 4'h0, 0, 4'h0, 1,  4'h0, 4'h0, 0, 2'd3, 4'h0);
        // masked pending channel, unmask makes it eligible
        add(1, 4'h0, 1, 4'h2, 0,  4'h0, 4'h2, 0, 2'd3, 4'h0);
        add(1, 4'h2, 0, 4'h0, 0,  4'h2, 4'h2, 0, 2'd3, 4'h0);
        add(1, 4'h0, 0, 4'h0, 0,  4'h2, 4'h2, 0, 2'd3, 4'h0);
        add(1, 4'h0, 1, 4'h0, 0,  4'h2, 4'h0, 0, 2'd3, 4'h0);
        add(1, 4'h0, 0, 4'h0, 0,  4'h2, 4'h0, 1, 2'd1, 4'h0);
        add(1, 4'h0, 0, 4'h0, 1,  4'h0, 4'h0, 0, 2'd1, 4'h0);
        // pulse+ack same channel re-presents, mask on presented channel
        add(1, 4'h8, 0, 4'h0, 0,  4'h8, 4'h0, 0, 2'd1, 4'h0);
        add(1, 4'h0, 0, 4'h0, 0,  4'h8, 4'h0, 1, 2'd3, 4'h0);
        add(1, 4'h8, 0, 4'h0, 1,  4'h8, 4'h0, 0, 2'd3, 4'h0);
        add(1, 4'h0, 0, 4'h0, 0,  4'h8, 4'h0, 1, 2'd3, 4'h0);
        add(1, 4'h0, 1, 4'h8, 0,  4'h8, 4'h8, 1, 2'd3, 4'h0);
        add(1, 4'h0, 0, 4'h0, 1,  4'h0, 4'h8, 0, 2'd3, 4'h0);
        add(1, 4'h0, 1, 4'h0, 0,  4'h0, 4'h0, 0, 2'd3, 4'h0);
        // lost pulse on ch0, cleared by its ack
        add(1, 4'h1, 0, 4'h0, 0,  4'h1, 4'h0, 0, 2'd3, 4'h0);
        add(1, 4'h1, 0, 4'h0, 0,  4'h1, 4'h0, 1, 2'd0, 4'h1);
        add(1, 4'h0, 0, 4'h0, 0,  4'h1, 4'h0, 1, 2'd0, 4'h1);
        add(1, 4'h0, 0, 4'h0, 1,  4'h0, 4'h0, 0, 2'd0, 4'h0);
        // all masked: pending accumulates, nothing presented
        add(1, 4'h0, 1, 4'hF, 0,  4'h0, 4'hF, 0, 2'd0, 4'h0);
        add(1, 4'h6, 0, 4'h0, 0,  4'h6, 4'hF, 0, 2'd0, 4'h0);
        add(1, 4'h0, 0, 4'h0, 0,  4'h6, 4'hF, 0, 2'd0, 4'h0);
        add(1, 4'h0, 0, 4'h0, 0,  4'h6, 4'hF, 0, 2'd0, 4'h0);
        // reset while presenting drops everything
        add(1, 4'h0, 1, 4'h0, 0,  4'h6, 4'h0, 0, 2'd0, 4'h0);
        add(1, 4'h0, 0, 4'h0, 0,  4'h6, 4'h0, 1, 2'd1, 4'h0);
        add(0, 4'h0, 0, 4'h0, 0,  4'h0, 4'hF, 0, 2'd0, 4'h0);
        add(1, 4'h0, 0, 4'h0, 0,  4'h0, 4'hF, 0, 2'd0, 4'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst_n, vecs[i].pulse, vecs[i].mwr, vecs[i].mdata, vecs[i].ack);
`ifdef PIT_IRQ_MISS_EN
            exp_miss = vecs[i].miss;
`else
            exp_miss = 4'h0;
`endif
            chk("pending",   i, 32'(pending),   32'(vecs[i].pend));
            chk("mask",      i, 32'(mask),      32'(vecs[i].mask));
            chk("irq_valid", i, 32'(irq_valid), 32'(vecs[i].vld));
            chk("irq_id",    i, 32'(irq_id),    32'(vecs[i].id));
            chk("miss",      i, 32'(miss),      32'(exp_miss));
        end

        // Two simultaneous pulses after reset: ch1 first at pulse+2, ch2 after one low cycle.
        drive(1, 4'h6, 1, 4'h0, 0);
        lat = 1;
        for (int c = 0; c < 8 && !irq_valid; c++) begin
            drive(1, 4'h0, 0, 4'h0, 0);
            lat++;
        end
        chk("seq_latency", 100, 32'(lat), 32'd2);
        chk("seq_first_id", 100, 32'(irq_id), 32'd1);
        drive(1, 4'h0, 0, 4'h0, 1);
        chk("seq_gap_valid", 101, 32'(irq_valid), 32'd0);
        drive(1, 4'h0, 0, 4'h0, 0);
        chk("seq_second_valid", 102, 32'(irq_valid), 32'd1);
        chk("seq_second_id", 102, 32'(irq_id), 32'd2);
        drive(1, 4'h0, 0, 4'h0, 1);
        chk("seq_final_pending", 103, 32'(pending), 32'd0);
        chk("seq_final_valid", 103, 32'(irq_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
